irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Interrupt-entry and MRET sequencer for the core.
- Takes the registered interrupt vector from the IF/ID stage and arbitrates among the pending sources.
- On entry: stalls the front pipeline, writes mepc, mcause and mstatus over successive cycles, then redirects fetch to mtvec.
- On MRET: restores mstatus and redirects fetch to mepc.

Parameters:
- XLEN, 32, data/address width.
- CSR_MSTATUS, 12'h300, CSR address of mstatus.
- CSR_MEPC, 12'h341, CSR address of mepc.
- CSR_MCAUSE, 12'h342, CSR address of mcause.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- irq_i  in  4  registered IRQ vector {debug, plic, timer, swi} from IF/ID
- inst_addr_i  in  XLEN  address of the instruction currently in ID
- inst_valid_i  in  1  ID holds a real (non-NOP) instruction
- jump_pending_i  in  1  EX is redirecting this cycle; defer acceptance
- mret_i  in  1  ID instruction is MRET
- csr_mstatus_i  in  XLEN  current mstatus
- csr_mie_i  in  XLEN  current mie
- csr_mtvec_i  in  XLEN  current mtvec
- csr_mepc_i  in  XLEN  current mepc
- hold_o  out  1  stall request to PC/IF/ID
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- int_jump_o  out  1  fetch redirect strobe
- int_addr_o  out  XLEN  redirect target

Behaviour:
- Reset: clk and rstn are as already decided (rstn synchronous, active-low). On reset:
  - state goes to IDLE.
  - All outputs and latched registers (cause, epc, mstatus copy) go to 0.
  - Reset asserted mid-sequence aborts it: no further CSR writes, no jump.
- Enable rules (MIE = mstatus[3]):
  - swi is enabled when MIE & mie[3].
  - timer is enabled when MIE & mie[7].
  - plic is enabled when MIE & mie[11].
  - debug is unmaskable.
- Priority and mcause codes (highest first):
  - debug: 32'h8000_0010
  - plic: 32'h8000_000B
  - timer: 32'h8000_0007
  - swi: 32'h8000_0003
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, INT_JUMP, MRET_STATUS, MRET_JUMP.
- IDLE, accept conditions:
  - MRET path requires mret_i & inst_valid_i & !jump_pending_i.
  - IRQ path requires an enabled source & inst_valid_i & !jump_pending_i & !mret_i.
  - If both could apply, MRET wins; the interrupt is taken after MIE is restored.
- IDLE, on the accept cycle:
  - hold_o=1, combinational.
  - For an IRQ: latch epc=inst_addr_i, cause, and mstatus; go to SAVE_EPC.
  - For MRET: latch mstatus; go to MRET_STATUS.
- SAVE_EPC: write mepc=epc.
- SAVE_CAUSE: write mcause=cause.
- SAVE_STATUS: write the latched mstatus with MPIE(bit7)=old MIE, MIE=0, all other bits unchanged.
- INT_JUMP: int_jump_o=1, int_addr_o={mtvec[XLEN-1:2],2'b00}; then IDLE.
- MRET_STATUS: write mstatus with MIE=old MPIE, MPIE=1.
- MRET_JUMP: int_jump_o=1, int_addr_o=csr_mepc_i; then IDLE.
- Every non-IDLE state: hold_o=1, and csr_we_o=1 only in the three SAVE states and in MRET_STATUS.
- When idle: csr_we_o=0, int_jump_o=0, int_addr_o=0, csr_waddr_o=0, csr_wdata_o=0.
- Latency: interrupt redirect at accept+4 cycles, idle again at accept+5; MRET redirect at accept+2.
- Source deasserting mid-sequence: the latched cause is kept and the sequence completes.
- New IRQs during a sequence: ignored; re-evaluated in IDLE, where MIE is now 0 so only debug can preempt.
- The cycle after INT_JUMP/MRET_JUMP: inst_valid_i is low (flushed), so no back-to-back acceptance occurs.

Test Plan:
- Reset: hold rstn=0 for 2 cycles mid-sequence -> state IDLE, hold_o=0, csr_we_o=0, int_jump_o=0 next cycle.
- Timer IRQ:
  - Stimulus: mstatus=32'h8, mie=32'h80, irq_i=4'b0010, inst_addr_i=32'h100, mtvec=32'h200.
  - Required: writes mepc=32'h100, then mcause=32'h8000_0007, then mstatus=32'h80; int_jump_o=1 with int_addr_o=32'h200 at T+4; hold_o high T..T+4.
- Priority: irq_i=4'b1111 with all enabled -> mcause=32'h8000_0010; irq_i=4'b0111 -> 32'h8000_000B.
- Masking:
  - mstatus=0 with timer pending -> no acceptance.
  - mie=0, MIE=1, swi pending -> no acceptance.
  - Debug with mstatus=0 -> accepted.
- Deferral: jump_pending_i=1 or inst_valid_i=0 with an enabled IRQ -> hold_o=0 and stays IDLE; accepted on the first cycle both are clear.
- MRET:
  - Stimulus: mret_i=1 with mstatus=32'h80, mepc=32'h104, timer pending.
  - Required: mstatus written as 32'h88, int_addr_o=32'h104 at T+2, then the timer interrupt is accepted on a later valid instruction.

Source files
------------

// File: rtl/irq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : irq_sequencer                                                 |
// | Purpose  : interrupt-entry (mepc/mcause/mstatus save + mtvec redirect)   |
// |            and MRET (mstatus restore + mepc redirect) sequencer          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module irq_sequencer #(
    parameter int          XLEN        = 32,
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [3:0]      irq_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic            inst_valid_i,
    input  logic            jump_pending_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    input  logic [XLEN-1:0] csr_mie_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    output logic            hold_o,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            int_jump_o,
    output logic [XLEN-1:0] int_addr_o
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SAVE_EPC    = 3'd1,
        SAVE_CAUSE  = 3'd2,
        SAVE_STATUS = 3'd3,
        INT_JUMP    = 3'd4,
        MRET_STATUS = 3'd5,
        MRET_JUMP   = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] mstatus_q;

    logic            mie_glb;
    logic            swi_en;
    logic            timer_en;
    logic            plic_en;
    logic            irq_any;
    logic            mret_acc;
    logic            irq_acc;
    logic [4:0]      cause_code;
    logic [XLEN-1:0] cause_sel;
    logic [XLEN-1:0] status_save;
    logic [XLEN-1:0] status_mret;
    logic            unused_bits;

    assign unused_bits = ^{csr_mie_i[XLEN-1:12], csr_mie_i[10:8], csr_mie_i[6:4],
                           csr_mie_i[2:0], csr_mtvec_i[1:0]};

    assign mie_glb  = csr_mstatus_i[3];
    assign swi_en   = irq_i[0] & mie_glb & csr_mie_i[3];
    assign timer_en = irq_i[1] & mie_glb & csr_mie_i[7];
    assign plic_en  = irq_i[2] & mie_glb & csr_mie_i[11];
    assign irq_any  = irq_i[3] | plic_en | timer_en | swi_en;

    // MRET takes precedence so a pending interrupt is taken after MIE is restored
    assign mret_acc = mret_i & inst_valid_i & ~jump_pending_i;
    assign irq_acc  = irq_any & inst_valid_i & ~jump_pending_i & ~mret_i;

    always_comb begin
        cause_code = 5'd0;
        if (irq_i[3])      cause_code = 5'h10;
        else if (plic_en)  cause_code = 5'h0B;
        else if (timer_en) cause_code = 5'h07;
        else if (swi_en)   cause_code = 5'h03;
        cause_sel           = '0;
        cause_sel[XLEN-1]   = 1'b1;
        cause_sel[4:0]      = cause_code;
    end

    always_comb begin
        status_save    = mstatus_q;
        status_save[7] = mstatus_q[3];
        status_save[3] = 1'b0;
        status_mret    = mstatus_q;
        status_mret[3] = mstatus_q[7];
        status_mret[7] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cause     <= '0;
            epc       <= '0;
            mstatus_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && mret_acc) begin
                mstatus_q <= csr_mstatus_i;
            end else if (state == IDLE && irq_acc) begin
                epc       <= inst_addr_i;
                cause     <= cause_sel;
                mstatus_q <= csr_mstatus_i;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_o      = 1'b0;
        csr_we_o    = 1'b0;
        csr_waddr_o = 12'h000;
        csr_wdata_o = '0;
        int_jump_o  = 1'b0;
        int_addr_o  = '0;
        // Outputs are gated during reset so an aborted sequence emits nothing
        if (rstn) begin
            case (state)
                IDLE: begin
                    hold_o = mret_acc | irq_acc;
                    if (mret_acc)     state_nxt = MRET_STATUS;
                    else if (irq_acc) state_nxt = SAVE_EPC;
                end
                SAVE_EPC: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MEPC;
                    csr_wdata_o = epc;
                    state_nxt   = SAVE_CAUSE;
                end
                SAVE_CAUSE: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MCAUSE;
                    csr_wdata_o = cause;
                    state_nxt   = SAVE_STATUS;
                end
                SAVE_STATUS: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = status_save;
                    state_nxt   = INT_JUMP;
                end
                INT_JUMP: begin
                    hold_o     = 1'b1;
                    int_jump_o = 1'b1;
                    int_addr_o = {csr_mtvec_i[XLEN-1:2], 2'b00};
                    state_nxt  = IDLE;
                end
                MRET_STATUS: begin
                    hold_o      = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = status_mret;
                    state_nxt   = MRET_JUMP;
                end
                MRET_JUMP: begin
                    hold_o     = 1'b1;
                    int_jump_o = 1'b1;
                    int_addr_o = csr_mepc_i;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_irq_sequencer                                              |
// | Purpose  : directed and randomized self-checking bench for irq_sequencer |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  irq_i;
    logic [31:0] inst_addr_i;
    logic        inst_valid_i;
    logic        jump_pending_i;
    logic        mret_i;
    logic [31:0] csr_mstatus_i;
    logic [31:0] csr_mie_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic        hold_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        int_jump_o;
    logic [31:0] int_addr_o;

    int vectors     = 0;
    int miscompares = 0;

    irq_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .irq_i(irq_i), .inst_addr_i(inst_addr_i),
        .inst_valid_i(inst_valid_i), .jump_pending_i(jump_pending_i), .mret_i(mret_i),
        .csr_mstatus_i(csr_mstatus_i), .csr_mie_i(csr_mie_i), .csr_mtvec_i(csr_mtvec_i),
        .csr_mepc_i(csr_mepc_i), .hold_o(hold_o), .csr_we_o(csr_we_o),
        .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .int_jump_o(int_jump_o),
        .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    // Packed view of all outputs: {hold, we, waddr, wdata, jump, addr}
    function automatic logic [78:0] obs();
        return {hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_jump_o, int_addr_o};
    endfunction

    function automatic logic [78:0] pk(logic h, logic we, logic [11:0] wa, logic [31:0] wd,
                                       logic j, logic [31:0] ja);
        return {h, we, wa, wd, j, ja};
    endfunction

    // Expected outputs k cycles after an interrupt is accepted
    function automatic logic [78:0] seq_exp(int k, logic [31:0] epc, logic [31:0] cause,
                                            logic [31:0] ms, logic [31:0] tvec);
        logic [31:0] s;
        s    = ms;
        s[7] = ms[3];
        s[3] = 1'b0;
        case (k)
            0:       return pk(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
            1:       return pk(1'b1, 1'b1, 12'h341, epc, 1'b0, 32'h0);
            2:       return pk(1'b1, 1'b1, 12'h342, cause, 1'b0, 32'h0);
            3:       return pk(1'b1, 1'b1, 12'h300, s, 1'b0, 32'h0);
            4:       return pk(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, tvec & 32'hFFFF_FFFC);
            default: return '0;
        endcase
    endfunction

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        jump;
        logic [1:0]  live;   // 0: no target, 1: aligned mtvec, 2: mepc
    } rec_t;

    rec_t pend[$];

    // Highest-priority enabled source index (3=debug .. 0=swi), or -1
    function automatic int pick_src();
        int mie_idx [3] = '{3, 7, 11};
        for (int i = 3; i >= 0; i--) begin
            if (irq_i[i]) begin
                if (i == 3) return 3;
                if (csr_mstatus_i[3] && csr_mie_i[mie_idx[i]]) return i;
            end
        end
        return -1;
    endfunction

    function automatic logic [78:0] model_eval();
        rec_t        r;
        logic [31:0] tgt;
        logic        acc;
        if (!rstn) return '0;
        if (pend.size() != 0) begin
            r   = pend[0];
            tgt = (r.live == 2'd1) ? (csr_mtvec_i & 32'hFFFF_FFFC) :
                  (r.live == 2'd2) ? csr_mepc_i : 32'h0;
            return {1'b1, r.we, r.waddr, r.wdata, r.jump, tgt};
        end
        acc = inst_valid_i && !jump_pending_i && (mret_i || pick_src() >= 0);
        return pk(acc, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
    endfunction

    task automatic model_advance();
        int          src;
        logic [31:0] codes [4] = '{32'h8000_0003, 32'h8000_0007, 32'h8000_000B, 32'h8000_0010};
        logic [31:0] s;
        src = pick_src();
        if (!rstn) begin
            pend.delete();
        end else if (pend.size() != 0) begin
            void'(pend.pop_front());
        end else if (inst_valid_i && !jump_pending_i && mret_i) begin
            s    = csr_mstatus_i;
            s[3] = csr_mstatus_i[7];
            s[7] = 1'b1;
            pend.push_back('{1'b1, 12'h300, s, 1'b0, 2'd0});
            pend.push_back('{1'b0, 12'h000, 32'h0, 1'b1, 2'd2});
        end else if (inst_valid_i && !jump_pending_i && src >= 0) begin
            s    = csr_mstatus_i;
            s[7] = csr_mstatus_i[3];
            s[3] = 1'b0;
            pend.push_back('{1'b1, 12'h341, inst_addr_i, 1'b0, 2'd0});
            pend.push_back('{1'b1, 12'h342, codes[src], 1'b0, 2'd0});
            pend.push_back('{1'b1, 12'h300, s, 1'b0, 2'd0});
            pend.push_back('{1'b0, 12'h000, 32'h0, 1'b1, 2'd1});
        end
    endtask

    // ---------------- helpers ----------------
    task automatic quiet_inputs();
        irq_i = 4'b0; inst_valid_i = 1'b0; jump_pending_i = 1'b0; mret_i = 1'b0;
    endtask

    task automatic idle_cycles(int n);
        quiet_inputs();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        quiet_inputs();
        inst_addr_i = 32'h0; csr_mstatus_i = 32'h0; csr_mie_i = 32'h0;
        csr_mtvec_i = 32'h0; csr_mepc_i = 32'h0;
        for (int k = 0; k < 2; k++) begin
            #3; vectors++;
            if (obs() !== 79'h0) begin
                miscompares++; $display("FAIL reset_init[%0d]: got %h want 0", k, obs());
            end
            @(posedge clk); #1;
        end
        rstn = 1'b1;
        csr_mstatus_i = 32'h8; csr_mie_i = 32'h80; irq_i = 4'b0010;
        inst_addr_i = 32'h100; csr_mtvec_i = 32'h200; inst_valid_i = 1'b1;
        #3; vectors++;
        if (hold_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_pre_accept: hold got %b want 1", hold_o);
        end
        @(posedge clk); #1;
        quiet_inputs();
        #3; vectors++;
        if (obs() !== seq_exp(1, 32'h100, 0, 0, 0)) begin
            miscompares++; $display("FAIL reset_pre_epc: got %h want %h", obs(), seq_exp(1, 32'h100, 0, 0, 0));
        end
        @(posedge clk); #1;
        rstn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) rstn = 1'b1;
            #3; vectors++;
            if (obs() !== 79'h0) begin
                miscompares++; $display("FAIL reset_abort[%0d]: got %h want 0", k, obs());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timer();
        logic [78:0] e;
        csr_mstatus_i = 32'h8; csr_mie_i = 32'h80; irq_i = 4'b0010;
        inst_addr_i = 32'h100; csr_mtvec_i = 32'h200; inst_valid_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin
                // source drops and mstatus changes; latched copies must be used
                quiet_inputs(); csr_mstatus_i = 32'h0; csr_mtvec_i = 32'h203;
            end
            e = seq_exp(k, 32'h100, 32'h8000_0007, 32'h8, 32'h200);
            #3; vectors++;
            if (obs() !== e) begin
                miscompares++; $display("FAIL timer_seq[%0d]: got %h want %h", k, obs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        logic [3:0]  pats  [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
        logic [31:0] cause [4] = '{32'h8000_0010, 32'h8000_000B, 32'h8000_0007, 32'h8000_0003};
        logic [78:0] e;
        for (int p = 0; p < 4; p++) begin
            csr_mstatus_i = 32'h0000_1808; csr_mie_i = 32'h888; csr_mtvec_i = 32'h400;
            irq_i = pats[p]; inst_addr_i = 32'h1000 + 32'(p * 4); inst_valid_i = 1'b1;
            for (int k = 0; k < 6; k++) begin
                if (k == 1) quiet_inputs();
                e = seq_exp(k, 32'h1000 + 32'(p * 4), cause[p], 32'h0000_1808, 32'h400);
                #3; vectors++;
                if (obs() !== e) begin
                    miscompares++; $display("FAIL prio_%0d[%0d]: got %h want %h", p, k, obs(), e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_masking();
        logic [31:0] ms  [4] = '{32'h0, 32'h8, 32'h8, 32'h8};
        logic [31:0] mie [4] = '{32'h80, 32'h0, 32'h80, 32'h0F7};
        logic [3:0]  irq [4] = '{4'b0010, 4'b0001, 4'b0001, 4'b0100};
        logic [78:0] e;
        for (int c = 0; c < 4; c++) begin
            csr_mstatus_i = ms[c]; csr_mie_i = mie[c]; irq_i = irq[c]; inst_valid_i = 1'b1;
            for (int k = 0; k < 2; k++) begin
                #3; vectors++;
                if (obs() !== 79'h0) begin
                    miscompares++; $display("FAIL mask_%0d[%0d]: got %h want 0", c, k, obs());
                end
                @(posedge clk); #1;
            end
        end
        // debug is unmaskable
        csr_mstatus_i = 32'h0; csr_mie_i = 32'h0; irq_i = 4'b1000;
        inst_addr_i = 32'h2000; csr_mtvec_i = 32'h800;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) quiet_inputs();
            e = seq_exp(k, 32'h2000, 32'h8000_0010, 32'h0, 32'h800);
            #3; vectors++;
            if (obs() !== e) begin
                miscompares++; $display("FAIL debug_seq[%0d]: got %h want %h", k, obs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_deferral();
        logic [78:0] e;
        csr_mstatus_i = 32'h8; csr_mie_i = 32'h80; irq_i = 4'b0010;
        inst_addr_i = 32'h3000; csr_mtvec_i = 32'h500;
        for (int k = 0; k < 5; k++) begin
            inst_valid_i   = (k != 2 && k != 3);
            jump_pending_i = (k < 2);
            mret_i         = (k == 4);   // MRET under a pending jump is deferred too
            jump_pending_i = jump_pending_i | (k == 4);
            #3; vectors++;
            if (obs() !== 79'h0) begin
                miscompares++; $display("FAIL defer[%0d]: got %h want 0", k, obs());
            end
            @(posedge clk); #1;
        end
        mret_i = 1'b0; jump_pending_i = 1'b0; inst_valid_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) quiet_inputs();
            e = seq_exp(k, 32'h3000, 32'h8000_0007, 32'h8, 32'h500);
            #3; vectors++;
            if (obs() !== e) begin
                miscompares++; $display("FAIL defer_accept[%0d]: got %h want %h", k, obs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mret();
        logic [78:0] e [4];
        e[0] = pk(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
        e[1] = pk(1'b1, 1'b1, 12'h300, 32'h88, 1'b0, 32'h0);
        e[2] = pk(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 32'h104);
        e[3] = '0;
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; csr_mie_i = 32'h80; csr_mtvec_i = 32'h200;
        irq_i = 4'b0010; mret_i = 1'b1; inst_valid_i = 1'b1; inst_addr_i = 32'h50;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin mret_i = 1'b0; inst_valid_i = 1'b0; csr_mstatus_i = 32'h0; end
            #3; vectors++;
            if (obs() !== e[k]) begin
                miscompares++; $display("FAIL mret_seq[%0d]: got %h want %h", k, obs(), e[k]);
            end
            @(posedge clk); #1;
        end
        // MIE is now restored; the still-pending timer is taken
        csr_mstatus_i = 32'h88; inst_valid_i = 1'b1; inst_addr_i = 32'h104;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) quiet_inputs();
            #3; vectors++;
            if (obs() !== seq_exp(k, 32'h104, 32'h8000_0007, 32'h88, 32'h200)) begin
                miscompares++;
                $display("FAIL mret_then_irq[%0d]: got %h want %h", k, obs(), seq_exp(k, 32'h104, 32'h8000_0007, 32'h88, 32'h200));
            end
            @(posedge clk); #1;
        end
        // other mstatus bits pass through; MPIE=0 restores MIE=0
        csr_mstatus_i = 32'h0000_1808; mret_i = 1'b1; inst_valid_i = 1'b1;
        @(posedge clk); #1;
        quiet_inputs();
        #3; vectors++;
        if (obs() !== pk(1'b1, 1'b1, 12'h300, 32'h0000_1880, 1'b0, 32'h0)) begin
            miscompares++; $display("FAIL mret_bits: got %h want mstatus 00001880", obs());
        end
        idle_cycles(2);
    endtask

    task automatic test_random();
        logic [78:0] e;
        rstn = 1'b0;
        quiet_inputs();
        for (int n = 0; n < 600; n++) begin
            if (n > 0) begin
                rstn           = ($urandom_range(0, 63) != 0);
                irq_i          = 4'($urandom_range(0, 15));
                inst_valid_i   = ($urandom_range(0, 3) != 0);
                jump_pending_i = ($urandom_range(0, 3) == 0);
                mret_i         = ($urandom_range(0, 7) == 0);
                csr_mstatus_i  = $urandom;
                csr_mie_i      = $urandom;
                csr_mtvec_i    = $urandom;
                csr_mepc_i     = $urandom;
                inst_addr_i    = $urandom;
            end
            e = model_eval();
            #3; vectors++;
            if (obs() !== e) begin
                miscompares++; $display("FAIL random[%0d]: got %h want %h", n, obs(), e);
            end
            model_advance();
            @(posedge clk); #1;
        end
        rstn = 1'b1;
        idle_cycles(6);
    endtask

    initial begin
        test_reset();
        idle_cycles(2);
        test_timer();
        test_priority();
        test_masking();
        test_deferral();
        test_mret();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
